// File: rtl/hawkes_thinning_stage_pkg.sv
// Shared types and widths for the Hawkes thinning stage.
package hawkes_thinning_stage_pkg;
    localparam int              LAMBDA_W   = 12;
    localparam int              TIME_W     = 16;
    localparam logic [11:0]     LAMBDA_MAX = 12'hFFF;
    localparam logic [3:0]      BETA_MAX   = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;
endpackage

// File: rtl/hawkes_thinning_stage_event_fifo.sv
// Show-ahead synchronous FIFO holding event timestamps; flush empties it in one cycle.
module event_fifo
    import hawkes_thinning_stage_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [TIME_W-1:0] din_i,
    input  logic              pop_i,
    output logic [TIME_W-1:0] dout_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [TIME_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_q, rd_q;
    logic              do_push, do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= din_i;
                wr_q                <= wr_q + (AW+1)'(1);
            end
            if (do_pop) rd_q <= rd_q + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/hawkes_thinning_stage.sv
// Discrete-time Hawkes process: intensity decays toward mu, jumps by alpha on each event.
module hawkes_thinning_stage
    import hawkes_thinning_stage_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [15:0]         n_steps,
    input  logic [11:0]         mu,
    input  logic [11:0]         alpha,
    input  logic [3:0]          beta_shift,
    input  logic [7:0]          rnd,
    input  logic                rnd_valid,
    output logic                busy,
    output logic                done,
    output logic [11:0]         lambda,
    output logic [15:0]         ev_count,
    output logic                overflow,
    output logic                ev_valid,
    output logic [TIME_W-1:0]   ev_time,
    input  logic                ev_ready
);
    state_e              state_q, state_d;
    logic [15:0]         n_q;
    logic [11:0]         mu_q, alpha_q;
    logic [3:0]          beta_q;
    logic [11:0]         lambda_q, lambda_d;
    logic [TIME_W-1:0]   t_q, t_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                start_ok, hit, flush, push, pop, fifo_full, fifo_empty;
    logic [11:0]         decay;
    logic [12:0]         sum;

    assign start_ok = start && (state_q != ST_RUN);
    assign hit      = rnd < lambda_q[11:4];
    // lambda >= mu always holds, so the subtraction cannot wrap.
    assign decay    = (lambda_q - mu_q) >> beta_q;
    assign sum      = {1'b0, lambda_q - decay} + {1'b0, hit ? alpha_q : 12'd0};
    assign pop      = ev_valid && ev_ready;

    always_comb begin
        state_d  = state_q;
        lambda_d = lambda_q;
        t_d      = t_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        flush    = 1'b0;
        push     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (n_q == 16'd0) begin
                    state_d = ST_DONE;
                end else if (rnd_valid) begin
                    lambda_d = sum[12] ? LAMBDA_MAX : sum[11:0];
                    t_d      = t_q + 16'd1;
                    if (hit) begin
                        push  = 1'b1;
                        cnt_d = cnt_q + 16'd1;
                        if (fifo_full && !pop) ovf_d = 1'b1;
                    end
                    if (t_q == n_q - 16'd1) state_d = ST_DONE;
                end
            end
            default: begin
                if (start) begin
                    state_d  = ST_RUN;
                    lambda_d = mu;
                    t_d      = '0;
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
                    flush    = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            lambda_q <= '0;
            t_q      <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            n_q      <= '0;
            mu_q     <= '0;
            alpha_q  <= '0;
            beta_q   <= '0;
        end else begin
            state_q  <= state_d;
            lambda_q <= lambda_d;
            t_q      <= t_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            if (start_ok) begin
                n_q     <= n_steps;
                mu_q    <= mu;
                alpha_q <= alpha;
                beta_q  <= (beta_shift > BETA_MAX) ? BETA_MAX : beta_shift;
            end
        end
    end

    event_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .push_i  (push),
        .din_i   (t_q),
        .pop_i   (pop),
        .dout_o  (ev_time),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign ev_valid = !fifo_empty;
    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign lambda   = lambda_q;
    assign ev_count = cnt_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_hawkes_thinning_stage.sv
// Randomized and directed bench for hawkes_thinning_stage against a queue-based reference model.
module tb_hawkes_thinning_stage;
    localparam int DEPTH = 4;

    logic        clk, rst_n, start, rnd_valid, ev_ready;
    logic [15:0] n_steps;
    logic [11:0] mu, alpha;
    logic [3:0]  beta_shift;
    logic [7:0]  rnd;
    logic        busy, done, overflow, ev_valid;
    logic [11:0] lambda;
    logic [15:0] ev_count, ev_time;

    int vectors = 0;
    int miscompares = 0;

    // reference model state (0 idle, 1 run, 2 done)
    int m_state, m_lambda, m_t, m_cnt, m_ovf, m_n, m_mu, m_alpha, m_beta;
    int mq[$];

    hawkes_thinning_stage #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_steps(n_steps), .mu(mu),
        .alpha(alpha), .beta_shift(beta_shift), .rnd(rnd), .rnd_valid(rnd_valid),
        .busy(busy), .done(done), .lambda(lambda), .ev_count(ev_count),
        .overflow(overflow), .ev_valid(ev_valid), .ev_time(ev_time), .ev_ready(ev_ready)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [47:0] obs();
        return {busy, done, lambda, ev_count, overflow, ev_valid, ev_time};
    endfunction

    function automatic logic [47:0] expv();
        logic [15:0] head;
        head = (mq.size() > 0) ? 16'(mq[0]) : 16'h0;
        return {m_state == 1, m_state == 2, 12'(m_lambda), 16'(m_cnt), m_ovf[0],
                mq.size() > 0, head};
    endfunction

    task automatic model_reset();
        m_state = 0; m_lambda = 0; m_t = 0; m_cnt = 0; m_ovf = 0;
        mq.delete();
    endtask

    // Advance the model by one clock edge given the inputs presented to it.
    task automatic model_step(input bit st, input bit rv, input int r, input bit rdy);
        bit pop, was_full, hit;
        int d, nl;
        pop      = (mq.size() > 0) && rdy;
        was_full = (mq.size() == DEPTH);
        if (!rst_n) begin
            model_reset();
        end else if (st && m_state != 1) begin
            m_n = n_steps; m_mu = mu; m_alpha = alpha;
            m_beta = (beta_shift > 11) ? 11 : beta_shift;
            m_lambda = m_mu; m_t = 0; m_cnt = 0; m_ovf = 0; m_state = 1;
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_state == 1) begin
                if (m_n == 0) m_state = 2;
                else if (rv) begin
                    hit = r < (m_lambda / 16);
                    d   = (m_lambda - m_mu) / (1 << m_beta);
                    nl  = m_lambda - d + (hit ? m_alpha : 0);
                    if (nl > 4095) nl = 4095;
                    if (hit) begin
                        m_cnt = (m_cnt + 1) % 65536;
                        if (was_full && !pop) m_ovf = 1;
                        else mq.push_back(m_t);
                    end
                    m_t++;
                    if (m_t == m_n) m_state = 2;
                    m_lambda = nl;
                end
            end
        end
    endtask

    // Present inputs at a falling edge, advance the model, land on the next falling edge.
    task automatic tick(input bit st, input bit rv, input logic [7:0] r, input bit rdy);
        start = st; rnd_valid = rv; rnd = r; ev_ready = rdy;
        model_step(st, rv, int'(r), rdy);
        @(negedge clk);
    endtask

    task automatic set_params(input int n, input int m, input int a, input int b);
        n_steps = 16'(n); mu = 12'(m); alpha = 12'(a); beta_shift = 4'(b);
    endtask

    task automatic test_reset();
        rst_n = 0;
        set_params(5, 12'hFFF, 12'h100, 1);
        for (int i = 0; i < 3; i++) begin
            tick(1, 1, 8'h00, 1);
            if (obs() !== 48'h0) begin
                $display("FAIL reset_hold obs=%h exp=%h", obs(), 48'h0);
                miscompares++;
            end
            vectors++;
        end
        rst_n = 1;
        set_params(8, 12'hFFF, 12'h100, 1);
        tick(1, 0, 8'h00, 0);
        for (int i = 0; i < 10; i++) begin
            tick(0, 1, 8'hFF, 0);
            if (obs() !== expv()) begin
                $display("FAIL reset_ff_stream obs=%h exp=%h", obs(), expv());
                miscompares++;
            end
            vectors++;
        end
        if (ev_count !== 16'd0 || ev_valid !== 1'b0 || done !== 1'b1) begin
            $display("FAIL ff_never_hits cnt=%0d valid=%b done=%b need 0/0/1", ev_count, ev_valid, done);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_bernoulli();
        logic [7:0] seq [4];
        seq = '{8'h10, 8'h90, 8'h7F, 8'h80};
        set_params(4, 12'h800, 0, 2);
        tick(1, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, seq[i], 0);
            if (obs() !== expv()) begin
                $display("FAIL bernoulli step%0d obs=%h exp=%h", i, obs(), expv());
                miscompares++;
            end
            vectors++;
        end
        if (ev_count !== 16'd2 || lambda !== 12'h800 || done !== 1'b1 || ev_time !== 16'd0) begin
            $display("FAIL bernoulli_end cnt=%0d lam=%h done=%b head=%0d need 2/800/1/0",
                     ev_count, lambda, done, ev_time);
            miscompares++;
        end
        vectors++;
        tick(0, 0, 8'h00, 1);
        if (ev_time !== 16'd2 || ev_valid !== 1'b1) begin
            $display("FAIL bernoulli_second head=%0d valid=%b need 2/1", ev_time, ev_valid);
            miscompares++;
        end
        vectors++;
        tick(0, 0, 8'h00, 1);
    endtask

    task automatic test_excitation();
        logic [11:0] want [5];
        want = '{12'h500, 12'h300, 12'h200, 12'h180, 12'h140};
        set_params(5, 12'h100, 12'h400, 1);
        tick(1, 0, 8'h00, 0);
        if (lambda !== 12'h100 || busy !== 1'b1) begin
            $display("FAIL excite_start lam=%h busy=%b need 100/1", lambda, busy);
            miscompares++;
        end
        vectors++;
        for (int i = 0; i < 5; i++) begin
            tick(0, 1, (i == 0) ? 8'h00 : 8'hFF, 0);
            if (lambda !== want[i] || obs() !== expv()) begin
                $display("FAIL excite step%0d lam=%h need %h obs=%h exp=%h", i, lambda, want[i], obs(), expv());
                miscompares++;
            end
            vectors++;
        end
        if (ev_count !== 16'd1 || ev_time !== 16'd0) begin
            $display("FAIL excite_events cnt=%0d head=%0d need 1/0", ev_count, ev_time);
            miscompares++;
        end
        vectors++;
        tick(0, 0, 8'h00, 1);
    endtask

    task automatic test_saturation();
        set_params(3, 12'hF00, 12'h400, 4);
        tick(1, 0, 8'h00, 1);
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 8'h00, 1);
            if (lambda !== 12'hFFF || obs() !== expv()) begin
                $display("FAIL saturate step%0d lam=%h need fff obs=%h exp=%h", i, lambda, obs(), expv());
                miscompares++;
            end
            vectors++;
        end
        for (int i = 0; i < 3; i++) tick(0, 0, 8'h00, 1);
    endtask

    task automatic test_overflow();
        set_params(6, 12'hFFF, 0, 3);
        tick(1, 0, 8'h00, 0);
        for (int i = 0; i < 6; i++) begin
            tick(0, 1, 8'h00, 0);
            if (obs() !== expv()) begin
                $display("FAIL overflow_fill step%0d obs=%h exp=%h", i, obs(), expv());
                miscompares++;
            end
            vectors++;
        end
        if (ev_count !== 16'd6 || overflow !== 1'b1) begin
            $display("FAIL overflow_flag cnt=%0d ovf=%b need 6/1", ev_count, overflow);
            miscompares++;
        end
        vectors++;
        for (int i = 0; i < 4; i++) begin
            if (ev_valid !== 1'b1 || ev_time !== 16'(i)) begin
                $display("FAIL overflow_drain%0d valid=%b head=%0d need 1/%0d", i, ev_valid, ev_time, i);
                miscompares++;
            end
            vectors++;
            tick(0, 0, 8'h00, 1);
        end
        if (ev_valid !== 1'b0) begin
            $display("FAIL overflow_empty valid=%b need 0", ev_valid);
            miscompares++;
        end
        vectors++;
        // fill to full, then push and pop together
        tick(1, 0, 8'h00, 0);
        for (int i = 0; i < 6; i++) begin
            tick(0, 1, 8'h00, i >= 4);
            if (obs() !== expv()) begin
                $display("FAIL full_pushpop step%0d obs=%h exp=%h", i, obs(), expv());
                miscompares++;
            end
            vectors++;
        end
        if (overflow !== 1'b0 || ev_time !== 16'd2) begin
            $display("FAIL full_pushpop_end ovf=%b head=%0d need 0/2", overflow, ev_time);
            miscompares++;
        end
        vectors++;
        for (int i = 0; i < 5; i++) tick(0, 0, 8'h00, 1);
    endtask

    task automatic test_edges();
        set_params(0, 12'hFFF, 0, 0);
        tick(1, 1, 8'h00, 0);
        tick(0, 1, 8'h00, 0);
        if (done !== 1'b1 || busy !== 1'b0 || ev_count !== 16'd0 || obs() !== expv()) begin
            $display("FAIL zero_steps obs=%h exp=%h", obs(), expv());
            miscompares++;
        end
        vectors++;
        // gaps stall, start during RUN ignored, beta clamp
        set_params(5, 12'h200, 12'h300, 15);
        tick(1, 0, 8'h00, 0);
        for (int i = 0; i < 12; i++) begin
            if (i == 3) set_params(9, 12'h555, 12'h111, 2);
            tick(i == 3, i % 2 == 1, 8'(i * 7), 1);
            if (obs() !== expv()) begin
                $display("FAIL gaps_restart cyc%0d obs=%h exp=%h", i, obs(), expv());
                miscompares++;
            end
            vectors++;
        end
        // asynchronous reset mid-run
        set_params(20, 12'hFFF, 0, 0);
        tick(1, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) tick(0, 1, 8'h00, 0);
        #2 rst_n = 0;
        #1;
        if (obs() !== 48'h0) begin
            $display("FAIL async_reset obs=%h exp=%h", obs(), 48'h0);
            miscompares++;
        end
        vectors++;
        model_reset();
        @(negedge clk);
        rst_n = 1;
        tick(0, 1, 8'h00, 1);
        if (obs() !== expv() || busy !== 1'b0) begin
            $display("FAIL reset_idle obs=%h exp=%h", obs(), expv());
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_random();
        int budget;
        for (int run = 0; run < 8; run++) begin
            set_params($urandom_range(40, 1), $urandom_range(4095, 0),
                       $urandom_range(4095, 0), $urandom_range(15, 0));
            tick(1, 0, 8'h00, $urandom_range(1, 0));
            budget = 0;
            while (m_state != 2 && budget < 300) begin
                tick($urandom_range(19, 0) == 0, $urandom_range(3, 0) != 0,
                     8'($urandom), $urandom_range(1, 0));
                if (obs() !== expv()) begin
                    $display("FAIL random run%0d obs=%h exp=%h", run, obs(), expv());
                    miscompares++;
                end
                vectors++;
                budget++;
            end
            if (budget >= 300) begin
                $display("FAIL random_timeout run%0d state=%0d need 2", run, m_state);
                miscompares++;
            end
        end
    endtask

    initial begin
        rst_n = 0; start = 0; rnd_valid = 0; rnd = 0; ev_ready = 0;
        n_steps = 0; mu = 0; alpha = 0; beta_shift = 0;
        model_reset();
        m_n = 0; m_mu = 0; m_alpha = 0; m_beta = 0;
        @(negedge clk);
        test_reset();
        test_bernoulli();
        test_excitation();
        test_saturation();
        test_overflow();
        test_edges();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hawkes_thinning_stage.md
# hawkes_thinning_stage

Consumes the 8-bit uniform random stream from the LFSR stage and turns it into a discrete-time self-exciting (Hawkes) event process. It keeps an intensity register that decays toward a baseline and jumps on each event. Each valid random sample is one time step; an event fires when the sample falls below the intensity. Event timestamps are buffered in a small FIFO with valid/ready handshake toward the downstream statistics/accumulator stage.

## Interface
- DEPTH, 4: event FIFO entries (power of 2, ≥2)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; honoured only in IDLE or DONE
- n_steps  in  16  run length in steps; latched on start
- mu  in  12  baseline intensity, unsigned Q0.12; latched on start
- alpha  in  12  excitation jump, Q0.12; latched on start
- beta_shift  in  4  decay shift 0..11; latched on start (values >11 treated as 11)
- rnd  in  8  uniform sample from LFSR
- rnd_valid  in  1  rnd valid this cycle; one step per valid cycle
- busy  out  1  high in RUN
- done  out  1  high in DONE
- lambda  out  12  current intensity
- ev_count  out  16  events in current/last run (wraps at 2^16)
- overflow  out  1  sticky: event dropped because FIFO full
- ev_valid  out  1  FIFO non-empty
- ev_time  out  16  step index of FIFO head event
- ev_ready  in  1  downstream pop

## Operation
- States IDLE → RUN → DONE → (start) RUN. Reset → IDLE.
- start in IDLE/DONE: latch params; lambda←mu; step counter t←0; ev_count←0; overflow←0; FIFO flushed; go RUN. start in RUN ignored.
- n_steps=0: RUN lasts one cycle, no steps processed, then DONE.
- Per step (RUN && rnd_valid): hit = (rnd < lambda[11:4]).
  - d = (lambda − mu) >> beta_shift (invariant lambda ≥ mu, so no underflow).
  - lambda_next = min(lambda − d + (hit ? alpha : 0), 12'hFFF), computed in 13 bits then saturated.
  - hit: push t into FIFO, ev_count+1; if FIFO full and no pop that cycle, drop entry, overflow←1.
  - t←t+1; after step index n_steps−1, go DONE.
- RUN && !rnd_valid: nothing changes.
- rnd=8'hFF never hits (max lambda[11:4]=8'hFF); LFSR reset value produces no events.
- FIFO drains in any state; pop when ev_valid && ev_ready.
- Reset values: state IDLE, busy 0, done 0, lambda 0, ev_count 0, overflow 0, ev_valid 0, ev_time 0, FIFO empty.
- rst_n low mid-run: immediate return to reset values; queued events discarded.

## Timing
- start at edge k → busy=1, lambda=mu from cycle k+1.
- Step sampled at edge k → lambda, ev_count, t updated cycle k+1; ev_valid/ev_time reflect pushed entry cycle k+1 (registered write, show-ahead head).
- Last step at edge k → busy=0, done=1 at k+1; done holds until next start.
- FIFO full with simultaneous push and pop: both succeed, no overflow.
- Pop at edge k → next head (or ev_valid=0) at k+1; ev_time stable while ev_valid && !ev_ready.
- Throughput: one step per clk.

## Structure
- Shared package: state enum (IDLE/RUN/DONE), LAMBDA_W=12, TIME_W=16, LAMBDA_MAX=12'hFFF.
- Sub-module event_fifo (synchronous FIFO, DEPTH×TIME_W, flush, push/pop, full/empty); intensity datapath and FSM in top.

## Test plan
- Reset: rst_n low with activity → all outputs 0, state IDLE; rnd=8'hFF stream after start never hits.
- Bernoulli: mu=0x800, alpha=0, beta=2, n_steps=4, rnd 0x10,0x90,0x7F,0x80 → ev_time 0 then 2, ev_count=2, lambda stays 0x800, done after 4th step.
- Excitation/decay: mu=0x100, alpha=0x400, beta=1, rnd 0x00 then 0xFF… → lambda 0x100→0x500→0x300→0x200→0x180; one event at t=0.
- Saturation: mu=0xF00, alpha=0x400, beta=4, rnd=0 → lambda 0xFFF, stays 0xFFF on next hit (d=0xF).
- Overflow: DEPTH=4, ev_ready=0, mu=0xFFF, rnd=0, n_steps=6 → ev_count=6, overflow=1; ev_ready=1 drains 0,1,2,3 in 4 cycles; full FIFO with push+pop same cycle → no overflow.
- Edges: n_steps=0 → done one cycle after busy, no events; rnd_valid gaps stall t/lambda; start during RUN ignored; rst_n mid-run → FIFO empty, IDLE.
